// File: rtl/pwm_capture.sv
// pwm_capture: measures period and on-time of an asynchronous PWM input and
// flags a stuck line when no rising edge arrives within TIMEOUT cycles.
`default_nettype none

module pwm_capture #(
  parameter int  PWM_INTERVAL = 1200,
  parameter int  TIMEOUT      = 2400,
  parameter bit  ACTIVE_LOW   = 1'b1,
  localparam int CNT_W        = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // A timeout shorter than the nominal period would flag every healthy line.
  if (TIMEOUT <= PWM_INTERVAL) begin : g_cfg_check
    $error("pwm_capture: TIMEOUT must exceed PWM_INTERVAL");
  end

  state_t           state, state_nxt;
  logic             sync1, sync2, lvl, lvl_d;
  logic             rise;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt;
  logic             take_sample, take_timeout;

  // lvl is registered so every output, level_o included, is 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      lvl   <= sync2 ^ ACTIVE_LOW;
      lvl_d <= lvl;
    end
  end

  assign rise    = lvl & ~lvl_d;
  assign level_o = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (cnt == TMO) ? cnt : cnt + ONE;
    hi_nxt       = (hi_cnt == TMO) ? hi_cnt : hi_cnt + {{(CNT_W-1){1'b0}}, lvl};
    take_sample  = 1'b0;
    take_timeout = 1'b0;
    // A rise coinciding with the timeout count is a legal sample.
    if (rise) begin
      cnt_nxt     = ONE;
      hi_nxt      = ONE;
      state_nxt   = MEASURE;
      take_sample = (state == MEASURE);
    end else if (cnt == TMO) begin
      cnt_nxt      = '0;
      hi_nxt       = '0;
      state_nxt    = IDLE;
      take_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      hi_cnt   <= '0;
      period_o <= '0;
      high_o   <= '0;
      valid_o  <= 1'b0;
      stuck_o  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      hi_cnt  <= hi_nxt;
      valid_o <= take_sample | take_timeout;
      if (take_sample) begin
        period_o <= cnt;
        high_o   <= hi_cnt;
        stuck_o  <= 1'b0;
      end else if (take_timeout) begin
        period_o <= '0;
        high_o   <= '0;
        stuck_o  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives both polarities of pwm_capture from one pin and checks
// every cycle against a sample-level model built from the pin history.
`default_nettype none

module tb_pwm_capture;

  localparam int TIMEOUT = 2400;
  localparam int W       = $clog2(TIMEOUT + 1);
  localparam int MAXC    = 100000;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period_o [2];
  logic [W-1:0] high_o   [2];
  logic         valid_o  [2];
  logic         stuck_o  [2];
  logic         level_o  [2];

  pwm_capture #(.ACTIVE_LOW(1'b0)) u_al0 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .period_o(period_o[0]), .high_o(high_o[0]), .valid_o(valid_o[0]),
    .stuck_o(stuck_o[0]), .level_o(level_o[0])
  );

  pwm_capture #(.ACTIVE_LOW(1'b1)) u_al1 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .period_o(period_o[1]), .high_o(high_o[1]), .valid_o(valid_o[1]),
    .stuck_o(stuck_o[1]), .level_o(level_o[1])
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  string nm [2] = '{"al0", "al1"};
  bit    al [2] = '{1'b0, 1'b1};

  // Reference model: cycle k counts rising clock edges since reset release.
  int cyc;
  bit pin_hist [MAXC];
  bit lvl_hist [2][MAXC];
  int anc      [2];
  bit meas     [2];
  int e_period [2];
  int e_high   [2];
  bit e_valid  [2];
  bit e_stuck  [2];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      anc[d] = 0; meas[d] = 1'b0;
      e_period[d] = 0; e_high[d] = 0; e_valid[d] = 1'b0; e_stuck[d] = 1'b0;
      lvl_hist[d][0] = 1'b0;
    end
  endtask

  // Called at a falling edge: drive one pin value across the next rising edge.
  task automatic tick(input bit pin);
    bit lk, rise;
    int s;
    pwm_in = pin;
    @(posedge clk);
    #1;
    cyc++;
    pin_hist[cyc] = pin;
    for (int d = 0; d < 2; d++) begin
      // level seen in cycle k is the pin sampled two edges earlier
      lk = ((cyc >= 3) ? pin_hist[cyc-2] : 1'b0) ^ al[d];
      check({nm[d], ".level"},  int'(level_o[d]),  int'(lk));
      check({nm[d], ".valid"},  int'(valid_o[d]),  int'(e_valid[d]));
      check({nm[d], ".stuck"},  int'(stuck_o[d]),  int'(e_stuck[d]));
      check({nm[d], ".period"}, int'(period_o[d]), e_period[d]);
      check({nm[d], ".high"},   int'(high_o[d]),   e_high[d]);
      rise = lk && !lvl_hist[d][cyc-1];
      lvl_hist[d][cyc] = lk;
      e_valid[d] = 1'b0;
      if (rise) begin
        if (meas[d]) begin
          s = 0;
          for (int i = anc[d]; i < cyc; i++) s += int'(lvl_hist[d][i]);
          e_period[d] = cyc - anc[d];
          e_high[d]   = s;
          e_valid[d]  = 1'b1;
          e_stuck[d]  = 1'b0;
        end
        anc[d]  = cyc;
        meas[d] = 1'b1;
      end else if (cyc - anc[d] == TIMEOUT) begin
        e_period[d] = 0;
        e_high[d]   = 0;
        e_valid[d]  = 1'b1;
        e_stuck[d]  = 1'b1;
        meas[d]     = 1'b0;
        anc[d]      = cyc + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_pwm(input int period, input int high, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < period; i++) tick(i < high);
  endtask

  task automatic run_level(input bit v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic check_zero_outputs(input string when);
    for (int d = 0; d < 2; d++) begin
      check({when, ".", nm[d], ".period"}, int'(period_o[d]), 0);
      check({when, ".", nm[d], ".high"},   int'(high_o[d]),   0);
      check({when, ".", nm[d], ".valid"},  int'(valid_o[d]),  0);
      check({when, ".", nm[d], ".stuck"},  int'(stuck_o[d]),  0);
      check({when, ".", nm[d], ".level"},  int'(level_o[d]),  0);
    end
  endtask

  task automatic spot(input string tag, input int d, input int per, input int hi, input int stk);
    check({tag, ".", nm[d], ".period"}, int'(period_o[d]), per);
    check({tag, ".", nm[d], ".high"},   int'(high_o[d]),   hi);
    check({tag, ".", nm[d], ".stuck"},  int'(stuck_o[d]),  stk);
  endtask

  initial begin
    int p, h, n;
    cyc = 0;
    repeat (3) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // 1/2: 300 pin-high cycles of 1200, seen as 300 (ACTIVE_LOW=0) and 900 (=1)
    run_pwm(1200, 300, 4);
    spot("p1200h300", 0, 1200, 300, 0);
    spot("p1200h300", 1, 1200, 900, 0);

    // 3: line held high
    run_level(1'b1, 5000);
    spot("stuck_hi", 0, 0, 0, 1);
    spot("stuck_hi", 1, 0, 0, 1);
    check("stuck_hi.al0.level", int'(level_o[0]), 1);
    check("stuck_hi.al1.level", int'(level_o[1]), 0);

    // 4: resume after stuck
    run_pwm(1200, 600, 3);
    spot("resume", 0, 1200, 600, 0);
    spot("resume", 1, 1200, 600, 0);

    // 5: reset mid-period
    for (int i = 0; i < 500; i++) tick(i < 600);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_pwm(1200, 600, 3);
    spot("post_reset", 0, 1200, 600, 0);

    // 6: period change
    run_pwm(500, 250, 4);
    spot("p500", 0, 500, 250, 0);
    spot("p500", 1, 500, 250, 0);

    // period equal to TIMEOUT is still a sample; one more cycle is not
    run_pwm(2400, 1000, 3);
    spot("p2400", 0, 2400, 1000, 0);
    spot("p2400", 1, 2400, 1400, 0);
    run_pwm(2401, 1000, 2);
    spot("p2401", 0, 0, 0, 1);

    // 0% duty on the pin
    run_level(1'b0, 3000);
    spot("stuck_lo", 0, 0, 0, 1);
    check("stuck_lo.al0.level", int'(level_o[0]), 0);
    check("stuck_lo.al1.level", int'(level_o[1]), 1);

    for (int s = 0; s < 6; s++) begin
      p = $urandom_range(2600, 4);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(3, 2);
      run_pwm(p, h, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
